// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceil-log2, default watermark levels and a watermark legality check.
// Pure constants and functions; no hardware.
package fifo_pkg;

    localparam int DEF_AFULL_LEVEL  = 28;
    localparam int DEF_AEMPTY_LEVEL = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Legal watermarks need 0 <= aempty < afull <= depth.
    function automatic bit thresholds_ok(input int depth, input int afull, input int aempty);
        return (aempty >= 0) && (aempty < afull) && (afull <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents not reset.
// Zero-cycle read latency; no flow control, the owner guards writes.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with watermarks, occupancy count, standard or FWFT read and sticky errors.
// Standard read: 1-cycle latency; FWFT: head word visible the cycle after it is written; full rejects writes, empty rejects reads.
module fifo_sync_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
    parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = clog2(DEPTH) + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t AFULL_P  = ptr_t'(AFULL_LEVEL);
    localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_LEVEL);

    if (!thresholds_ok(DEPTH, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_bad_thresholds
        $error("fifo_sync_flex: illegal AFULL_LEVEL/AEMPTY_LEVEL");
    end

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t level_q, level_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // All status flags decode from the registered level only.
    assign full         = (level_q == DEPTH_P);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AFULL_P);
    assign almost_empty = (level_q <= AEMPTY_P);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_acc);
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_acc);
        level_d  = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + ptr_t'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - ptr_t'(1);
        end
        // A fresh error event outranks a coincident clear.
        overflow_d  = (wr_en & full)  ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
        underflow_d = (rd_en & empty) ? 1'b1 : (clr_err ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so idle output is deterministic.
        assign data_out = empty ? '0 : ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  rd_valid_q, rd_valid_d;

        always_comb begin
            dout_d     = rd_acc ? ram_rdata : dout_q;
            rd_valid_d = rd_acc;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                dout_q     <= dout_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical traffic and checks both against a queue model.
module tb_fifo_sync_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;

    logic       s_full, s_afull, s_ovf, s_rvld, s_empty, s_aempty, s_unf;
    logic [7:0] s_dout;
    logic [5:0] s_level;
    logic       f_full, f_afull, f_ovf, f_rvld, f_empty, f_aempty, f_unf;
    logic [7:0] f_dout;
    logic [5:0] f_level;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;
    logic       m_vld  = 1'b0;
    logic [7:0] m_dout = '0;

    always #5 clk = ~clk;

    fifo_sync_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(0), .AFULL_LEVEL(28), .AEMPTY_LEVEL(4)) u_std (
        .clk(clk), .rst(rst), .clr_err(clr_err), .wr_en(wr_en), .data_in(data_in),
        .full(s_full), .almost_full(s_afull), .overflow(s_ovf), .rd_en(rd_en),
        .data_out(s_dout), .rd_valid(s_rvld), .empty(s_empty), .almost_empty(s_aempty),
        .underflow(s_unf), .level(s_level)
    );

    fifo_sync_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1), .AFULL_LEVEL(28), .AEMPTY_LEVEL(4)) u_fwft (
        .clk(clk), .rst(rst), .clr_err(clr_err), .wr_en(wr_en), .data_in(data_in),
        .full(f_full), .almost_full(f_afull), .overflow(f_ovf), .rd_en(rd_en),
        .data_out(f_dout), .rd_valid(f_rvld), .empty(f_empty), .almost_empty(f_aempty),
        .underflow(f_unf), .level(f_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("s_level",  32'(s_level),  32'(sz));
        chk("s_full",   32'(s_full),   32'(sz == 32));
        chk("s_empty",  32'(s_empty),  32'(sz == 0));
        chk("s_afull",  32'(s_afull),  32'(sz >= 28));
        chk("s_aempty", 32'(s_aempty), 32'(sz <= 4));
        chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
        chk("s_unf",    32'(s_unf),    32'(m_unf));
        chk("s_rvld",   32'(s_rvld),   32'(m_vld));
        chk("s_dout",   32'(s_dout),   32'(m_dout));
        chk("f_level",  32'(f_level),  32'(sz));
        chk("f_full",   32'(f_full),   32'(sz == 32));
        chk("f_empty",  32'(f_empty),  32'(sz == 0));
        chk("f_afull",  32'(f_afull),  32'(sz >= 28));
        chk("f_aempty", 32'(f_aempty), 32'(sz <= 4));
        chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
        chk("f_unf",    32'(f_unf),    32'(m_unf));
        chk("f_rvld",   32'(f_rvld),   32'(sz != 0));
        if (sz != 0) begin
            chk("f_dout", 32'(f_dout), 32'(q[0]));
        end
    endtask

    // One clock of traffic: model the queue semantics, then compare everything just after the edge.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit fm, em;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        fm    = (q.size() == 32);
        em    = (q.size() == 0);
        m_ovf = (w && fm) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = (r && em) ? 1'b1 : (c ? 1'b0 : m_unf);
        m_vld = 1'b0;
        if (r && !em) begin
            m_dout = q.pop_front();
            m_vld  = 1'b1;
        end
        if (w && !fm) begin
            q.push_back(d);
        end
        #1;
        check_all();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // Fill 0x00..0x1F, watermarks tracked by the model at every step
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);

        // Overflow, clear, and clear colliding with a new overflow
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(s_ovf), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain in order, then one read too many
        for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("last_word", 32'(s_dout), 32'h1F);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_hold_dout", 32'(s_dout), 32'h1F);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous read+write at level 10, at full and at empty
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        while (q.size() < 32) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_rw_level", 32'(s_level), 32'd31);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        chk("empty_rw_level", 32'(s_level), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // FWFT: head appears without rd_en, pop empties it
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_head", 32'(f_dout), 32'h5A);
        chk("fwft_vld", 32'(f_rvld), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_popped_empty", 32'(f_empty), 32'd1);

        // Random traffic across many pointer wraps, level held within 1..31
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (q.size() >= 31) w = 1'b0;
            if (q.size() <= 1)  r = 1'b0;
            cycle(w, 8'($urandom), r, 1'b0);
        end

        // Asynchronous reset mid-stream, checked before any clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_vld  = 1'b0;
        m_dout = '0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_word", 32'(s_dout), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
